frame_swap_arbiter: RTL and testbench

Double-buffered frame-memory controller between the host pixel-write path and the matrix scan engine. Owns the single-port SPRAM holding two frame banks. Grants every access to the scan reader with absolute priority, fits host writes into idle cycles, and swaps front/back banks only at a frame boundary so the panel never shows a torn frame. Sits between the host interface and the matrix data-shift state machine.

---
 rtl/frame_swap_arbiter_pkg.sv | 23 ++
 rtl/frame_swap_arbiter_if.sv | 37 +++
 rtl/frame_swap_arbiter_fb_port_mux.sv | 40 ++++
 rtl/frame_swap_arbiter.sv | 128 ++++++++++++
 tb/tb_frame_swap_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_swap_arbiter_pkg.sv
// Shared types and defaults for the double-buffered frame-memory controller.
package frame_swap_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int BOARDS     = 16;
    localparam int BANK_W     = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_COPY_RD,
        S_COPY_WR
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SCAN,
        GNT_COPY,
        GNT_HOST
    } grant_t;

endpackage

// File: rtl/frame_swap_arbiter_if.sv
// Host write, swap control, scan read and SPRAM port signals of the frame arbiter.
interface frame_swap_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit_req;
    logic              frame_boundary;
    logic              busy;
    logic              swap_done;
    logic              front_bank;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req, frame_boundary,
               rd_req, rd_addr, mem_rdata,
        input  wr_ready, busy, swap_done, front_bank, rd_valid, rd_data,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req, frame_boundary,
               rd_req, rd_addr, mem_rdata,
        output wr_ready, busy, swap_done, front_bank, rd_valid, rd_data,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/frame_swap_arbiter_fb_port_mux.sv
// SPRAM port mux: drives mem_* from whichever requester holds the grant.
module fb_port_mux
    import frame_swap_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  grant_t            i_grant,
    input  logic [ADDR_W:0]   i_scan_addr,
    input  logic [ADDR_W:0]   i_copy_addr,
    input  logic              i_copy_we,
    input  logic [DATA_W-1:0] i_copy_wdata,
    input  logic [ADDR_W:0]   i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic [ADDR_W:0]   o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata
);

    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        case (i_grant)
            GNT_SCAN: o_mem_addr = i_scan_addr;
            GNT_COPY: begin
                o_mem_addr  = i_copy_addr;
                o_mem_we    = i_copy_we;
                o_mem_wdata = i_copy_wdata;
            end
            GNT_HOST: begin
                o_mem_addr  = i_host_addr;
                o_mem_we    = 1'b1;
                o_mem_wdata = i_host_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/frame_swap_arbiter.sv
// Double-buffered frame-memory arbiter: scan reads first, then bank copy, then host writes.
// Optional front-to-back copy after each swap is enabled by defining FB_COPY_ON_SWAP_EN.
module frame_swap_arbiter
    import frame_swap_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    frame_swap_arbiter_if.slave bus
);

    state_t              r_state;
    logic [BANK_W-1:0]   r_front;
    logic                r_busy;
    logic                r_swap_done;
    logic                r_rd_valid;
    logic                r_cap;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_hold;

    grant_t              w_grant;
    logic                w_wr_ready;
    logic                w_copy_act;
    logic                w_copy_we;
    logic [DATA_W-1:0]   w_copy_wdata;
    logic [ADDR_W:0]     w_copy_addr;

    always_comb begin
        w_wr_ready = (r_state == S_IDLE) && !bus.rd_req && !rst;
        w_copy_act = ((r_state == S_COPY_RD) || (r_state == S_COPY_WR)) && !rst;
        w_copy_we  = (r_state == S_COPY_WR);
        w_copy_addr = w_copy_we ? {~r_front, r_idx} : {r_front, r_idx};
        // The copy read data is only on mem_rdata the cycle after the read; later it lives in r_hold.
        w_copy_wdata = r_cap ? bus.mem_rdata : r_hold;
        w_grant = GNT_NONE;
        if (bus.rd_req)
            w_grant = GNT_SCAN;
        else if (w_copy_act)
            w_grant = GNT_COPY;
        else if (w_wr_ready && bus.wr_valid)
            w_grant = GNT_HOST;
    end

    fb_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_port_mux (
        .i_grant      (w_grant),
        .i_scan_addr  ({r_front, bus.rd_addr}),
        .i_copy_addr  (w_copy_addr),
        .i_copy_we    (w_copy_we),
        .i_copy_wdata (w_copy_wdata),
        .i_host_addr  ({~r_front, bus.wr_addr}),
        .i_host_wdata (bus.wr_data),
        .o_mem_addr   (bus.mem_addr),
        .o_mem_we     (bus.mem_we),
        .o_mem_wdata  (bus.mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_front     <= '0;
            r_busy      <= 1'b0;
            r_swap_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_cap       <= 1'b0;
            r_idx       <= '0;
            r_hold      <= '0;
        end else begin
            r_rd_valid  <= bus.rd_req;
            r_swap_done <= 1'b0;
            r_cap       <= 1'b0;
            if (r_cap)
                r_hold <= bus.mem_rdata;
            case (r_state)
                S_IDLE: begin
                    if (bus.commit_req) begin
                        r_state <= S_PENDING;
                        r_busy  <= 1'b1;
                    end
                end
                S_PENDING: begin
                    if (bus.frame_boundary) begin
                        r_front <= ~r_front;
`ifdef FB_COPY_ON_SWAP_EN
                        r_state <= S_COPY_RD;
                        r_idx   <= '0;
`else
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_swap_done <= 1'b1;
`endif
                    end
                end
                S_COPY_RD: begin
                    if (!bus.rd_req) begin
                        r_state <= S_COPY_WR;
                        r_cap   <= 1'b1;
                    end
                end
                S_COPY_WR: begin
                    if (!bus.rd_req) begin
                        r_idx <= r_idx + ADDR_W'(1);
                        if (r_idx == '1) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_swap_done <= 1'b1;
                        end else begin
                            r_state <= S_COPY_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.busy       = r_busy;
    assign bus.swap_done  = r_swap_done;
    assign bus.front_bank = r_front;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = bus.mem_rdata;

endmodule

// File: tb/tb_frame_swap_arbiter.sv
// Bench for frame_swap_arbiter: directed steps plus random traffic against a bank-level model.
module tb_frame_swap_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int NW = 1 << AW;
`ifdef FB_COPY_ON_SWAP_EN
    localparam bit COPY_EN = 1'b1;
`else
    localparam bit COPY_EN = 1'b0;
`endif

    typedef enum {M_IDLE, M_WAIT, M_COPY} mphase_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_swap_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_swap_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // SPRAM stand-in with 1-cycle read latency, plus clear/preload hooks.
    logic [DW-1:0] spram [2*NW];
    logic          mem_clr = 1'b0;
    logic          pre_en  = 1'b0;
    logic [AW:0]   pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2*NW; i++) spram[i] <= '0;
        end else if (pre_en) begin
            spram[pre_addr] <= pre_data;
        end else if (bus.mem_we) begin
            spram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= spram[bus.mem_addr];
    end

    // Stimulus for the current cycle
    logic          s_rst, s_rd_req, s_wr_valid, s_commit, s_fb;
    logic [AW-1:0] s_rd_addr, s_wr_addr;
    logic [DW-1:0] s_wr_data;

    // Reference model: bank contents and swap progress
    logic [DW-1:0] bank [2][NW];
    mphase_t       m_mode;
    logic          m_front, m_swap, m_rdv;
    logic [DW-1:0] m_rdd;
    int unsigned   m_k;
    bit            reg_known = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_rst = 1'b0; s_rd_req = 1'b0; s_wr_valid = 1'b0; s_commit = 1'b0; s_fb = 1'b0;
        s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0;
    endtask

    task automatic cycle();
        logic          ex_ready, ex_we;
        logic [AW:0]   ex_addr;
        logic [DW-1:0] ex_wd;
        int unsigned   w;
        rst                = s_rst;
        bus.rd_req         = s_rd_req;
        bus.rd_addr        = s_rd_addr;
        bus.wr_valid       = s_wr_valid;
        bus.wr_addr        = s_wr_addr;
        bus.wr_data        = s_wr_data;
        bus.commit_req     = s_commit;
        bus.frame_boundary = s_fb;
        @(negedge clk);
        if (reg_known) begin
            chk("front_bank", 32'(bus.front_bank), 32'(m_front));
            chk("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
            chk("swap_done", 32'(bus.swap_done), 32'(m_swap));
            chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
            if (m_rdv) chk("rd_data", 32'(bus.rd_data), 32'(m_rdd));
        end
        if (s_rst) begin
            chk("wr_ready_in_reset", 32'(bus.wr_ready), 32'(0));
        end else begin
            ex_ready = (m_mode == M_IDLE) && !s_rd_req;
            ex_we = 1'b0; ex_addr = '0; ex_wd = '0;
            if (s_rd_req) begin
                ex_addr = {m_front, s_rd_addr};
            end else if (m_mode == M_COPY) begin
                w = m_k / 2;
                if (m_k % 2 == 0) begin
                    ex_addr = {m_front, AW'(w)};
                end else begin
                    ex_we = 1'b1; ex_addr = {~m_front, AW'(w)}; ex_wd = bank[m_front][w];
                end
            end else if (m_mode == M_IDLE && s_wr_valid) begin
                ex_we = 1'b1; ex_addr = {~m_front, s_wr_addr}; ex_wd = s_wr_data;
            end
            if (reg_known) begin
                chk("wr_ready", 32'(bus.wr_ready), 32'(ex_ready));
                chk("mem_we", 32'(bus.mem_we), 32'(ex_we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(ex_addr));
                if (ex_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(ex_wd));
            end
        end
        // advance the model by one clock
        if (s_rst) begin
            m_mode = M_IDLE; m_front = 1'b0; m_swap = 1'b0; m_rdv = 1'b0; m_k = 0;
            reg_known = 1'b1;
        end else begin
            m_swap = 1'b0;
            m_rdv  = s_rd_req;
            if (s_rd_req) m_rdd = bank[m_front][s_rd_addr];
            case (m_mode)
                M_IDLE: begin
                    if (s_wr_valid && !s_rd_req) bank[~m_front][s_wr_addr] = s_wr_data;
                    if (s_commit) m_mode = M_WAIT;
                end
                M_WAIT: begin
                    if (s_fb) begin
                        m_front = ~m_front;
                        if (COPY_EN) begin
                            m_mode = M_COPY; m_k = 0;
                        end else begin
                            m_mode = M_IDLE; m_swap = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!s_rd_req) begin
                        if (m_k % 2 == 1) bank[~m_front][m_k/2] = bank[m_front][m_k/2];
                        m_k++;
                        if (m_k == 2*NW) begin
                            m_mode = M_IDLE; m_swap = 1'b1;
                        end
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NW; i++) bank[b][i] = '0;
        m_mode = M_IDLE; m_front = 1'b0; m_swap = 1'b0; m_rdv = 1'b0; m_rdd = '0; m_k = 0;
        bus.mem_rdata = '0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset, clearing the memory stand-in alongside
        mem_clr = 1'b1;
        s_rst = 1'b1;
        cycle();
        cycle();
        mem_clr = 1'b0;
        idle_inputs();
        cycle();

        // Read latency: front bank 0, address 5 holds 0xA5
        pre_en = 1'b1; pre_addr = {1'b0, AW'(5)}; pre_data = 8'hA5;
        bank[0][5] = 8'hA5;
        cycle();
        pre_en = 1'b0;
        s_rd_req = 1'b1; s_rd_addr = AW'(5);
        cycle();
        idle_inputs();
        cycle();

        // Priority: scan reads hold off a pending host write for 4 cycles
        s_wr_valid = 1'b1; s_wr_addr = AW'(3); s_wr_data = 8'h77; s_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rd_addr = AW'($urandom_range(NW-1));
            cycle();
        end
        s_rd_req = 1'b0;
        cycle();
        idle_inputs();

        // Swap: write 0x3C to back address 0x10, commit, boundary 100 cycles later
        s_wr_valid = 1'b1; s_wr_addr = AW'(16); s_wr_data = 8'h3C;
        cycle();
        idle_inputs();
        s_commit = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 99; i++) begin
            s_wr_valid = ($urandom_range(3) == 0); s_wr_addr = AW'($urandom); s_wr_data = DW'($urandom);
            cycle();
        end
        idle_inputs();
        s_fb = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 400 && m_mode != M_IDLE; i++) begin
            s_rd_req = (i % 2 == 0); s_rd_addr = AW'($urandom);
            s_wr_valid = 1'b1; s_wr_addr = AW'($urandom); s_wr_data = DW'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();
        s_rd_req = 1'b1; s_rd_addr = AW'(16);
        cycle();
        idle_inputs();
        cycle();
        chk("readback_0x10", 32'(m_rdd), 32'h3C);

        // commit and boundary together: pend only, next boundary swaps
        s_commit = 1'b1; s_fb = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();
        s_fb = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 400 && m_mode != M_IDLE; i++) begin
            s_rd_req = (i % 2 == 1); s_rd_addr = AW'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            s_rd_req   = ($urandom_range(2) == 0);
            s_rd_addr  = AW'($urandom);
            s_wr_valid = ($urandom_range(1) == 0);
            s_wr_addr  = AW'($urandom);
            s_wr_data  = DW'($urandom);
            s_commit   = ($urandom_range(39) == 0);
            s_fb       = ($urandom_range(29) == 0);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 400 && m_mode != M_IDLE; i++) begin
            s_fb = (m_mode == M_WAIT);
            cycle();
        end
        idle_inputs();

        // Front bank sweep
        for (int i = 0; i < NW; i++) begin
            s_rd_req = 1'b1; s_rd_addr = AW'(i);
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset in the middle of a swap/copy (index 7 write phase when copying)
        s_commit = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        s_fb = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 200 && !(m_mode == M_COPY && m_k == 15); i++) cycle();
        s_rst = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        for (int i = 0; i < NW; i++) begin
            s_rd_req = 1'b1; s_rd_addr = AW'(i);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
